apb_seq_master: RTL and testbench
=================================

APB_SEQ_MASTER -- requirements
Module: apb_seq_master

Interface
REQ-001 Parameter APB_AW, 32, APB address width.
REQ-002 Parameter APB_DW, 32, APB data width.
REQ-003 Parameter DEPTH, 16, command-memory entries (power of 2, 2..256).
REQ-004 Parameter NUM_IRQ, 2, interrupt inputs (1..8).
REQ-005 Parameter CNT_W, 16, delay/timeout counter width.
REQ-006 Port list:
- PCLK  in  1  sole clock.
- PRESET  in  1  reset, asynchronous, active-high.
- cmd_we  in  1  command write strobe.
- cmd_waddr  in  log2(DEPTH)  command index.
- cmd_wdata  in  3+APB_AW+2*APB_DW  {op[2:0], addr, data, mask}.
- start  in  1  run-request pulse.
- busy  out  1  sequence running.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky failure flag.
- err_idx  out  log2(DEPTH)  index of failing command.
- rd_data  out  APB_DW  last read data.
- rd_valid  out  1  one-cycle pulse with rd_data.
- PSEL, PENABLE, PWRITE  out  1  APB master controls.
- PADDR  out  APB_AW;  PWDATA  out  APB_DW.
- PRDATA  in  APB_DW;  PREADY  in  1;  PSLVERR  in  1.
- irq  in  NUM_IRQ  level interrupts, synchronous to PCLK.

Function
REQ-007 Opcodes SHALL be: 0 NOP, 1 WR, 2 RD, 3 RDCMP, 4 WAITIRQ, 5 DELAY, 7 END; 6 SHALL behave as END.
REQ-008 FSM states SHALL be IDLE, FETCH, SETUP, ACCESS, WAIT, FIN.
REQ-009 start in IDLE SHALL clear error, set pc=0, raise busy next cycle, and enter FETCH; start outside IDLE SHALL be ignored.
REQ-010 FETCH SHALL read the registered memory (1-cycle latency), then decode.
REQ-011 WR/RD/RDCMP SHALL drive SETUP (PSEL=1, PENABLE=0) one cycle, then ACCESS (PENABLE=1) until PREADY=1; PADDR/PWRITE/PWDATA SHALL stay stable SETUP through the PREADY cycle.
REQ-012 The first PSEL after start SHALL occur 2 cycles after the start cycle.
REQ-013 On the PREADY cycle, RD/RDCMP SHALL capture PRDATA into rd_data and pulse rd_valid next cycle.
REQ-014 RDCMP SHALL fail when (PRDATA & mask) != (data & mask).
REQ-015 PSLVERR=1 with PREADY=1 SHALL fail the command.
REQ-016 WAITIRQ SHALL wait in WAIT until irq[data[2:0]] = 1 (pass) or mask[CNT_W-1:0] cycles elapse (fail); timeout 0 SHALL wait forever; an irq asserted in the first WAIT cycle SHALL pass.
REQ-017 DELAY SHALL remain in WAIT for exactly data[CNT_W-1:0] cycles (0 SHALL consume none).
REQ-018 NOP SHALL advance pc without an APB transfer.
REQ-019 Failure SHALL set error=1, err_idx=pc, and go to FIN without executing further commands.
REQ-020 END, or completion of entry DEPTH-1 (no wrap), SHALL go to FIN.
REQ-021 FIN SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-022 cmd_we SHALL be accepted only in IDLE; writes while busy SHALL be discarded.
REQ-023 PSEL and PENABLE SHALL be 0 in every state except SETUP/ACCESS.

Reset
REQ-024 PRESET=1 SHALL asynchronously force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, busy=done=error=rd_valid=0, err_idx=0, rd_data=0, and counters=0, including mid-transfer.
REQ-025 Command-memory contents SHALL NOT be reset.

Structure
REQ-026 Opcode constants, state encoding, and the command-field offsets SHALL live in the shared package apb_seq_pkg.
REQ-027 Command storage SHALL be the sub-module apb_seq_cmd_mem (1 write port, 1 registered read port, DEPTH x (3+APB_AW+2*APB_DW)).

Verification
REQ-028 Load {WR 0x10 0xA5A5_0000; END}, start, PREADY=1 -> PSEL 2 cycles after start, PENABLE next cycle, PWDATA=0xA5A5_0000, done 1 pulse, error=0.
REQ-029 Load {RDCMP 0x14 data 0x0000_00F0 mask 0x0000_00FF; END}, slave returns 0x1234_56F0 after 3 wait states -> PENABLE held 4 cycles, rd_valid with rd_data=0x1234_56F0, error=0.
REQ-030 Same RDCMP with PRDATA=0x0000_00F1 -> error=1, err_idx=0, next entry not executed, done pulses.
REQ-031 Load {WAITIRQ irq1 timeout 20; WR 0x0 1; END}, irq[1] raised at cycle 10 -> WR issued, done; repeat with irq never raised -> error after 20 WAIT cycles, err_idx=0.
REQ-032 Fill all 16 entries with NOP -> done after entry 15 with no wrap; start and cmd_we during busy ignored; PRESET asserted mid-ACCESS -> PSEL/PENABLE 0 immediately, busy=0.

Source files
------------

// File: rtl/apb_seq_pkg.sv
// Shared definitions for the APB command sequencer: opcodes, FSM states, command field layout.
// Latency: none (definitions only).
// Backpressure: not applicable.
package apb_seq_pkg;

    localparam int OP_W = 3;

    // Command opcodes; 6 is unassigned and decodes like END.
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_WR      = 3'd1,
        OP_RD      = 3'd2,
        OP_RDCMP   = 3'd3,
        OP_WAITIRQ = 3'd4,
        OP_DELAY   = 3'd5,
        OP_RSVD    = 3'd6,
        OP_END     = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_WAIT   = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    // Command word layout, MSB first: {op, addr, data, mask}.
    function automatic int cmd_width(input int aw, input int dw);
        return OP_W + aw + 2 * dw;
    endfunction

    function automatic int mask_lsb();
        return 0;
    endfunction

    function automatic int data_lsb(input int dw);
        return dw;
    endfunction

    function automatic int addr_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int op_lsb(input int aw, input int dw);
        return aw + 2 * dw;
    endfunction

endpackage

// File: rtl/apb_seq_cmd_mem.sv
// Command store: single write port, single registered read port, contents never reset.
// Latency: read data valid one cycle after the read address is presented.
// Backpressure: none; writes and reads are accepted every cycle.
module apb_seq_cmd_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 99
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Program load port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; the sequencer presents next-pc so data lands in the FETCH cycle.
    always_ff @(posedge clk_i) begin
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/apb_seq_master.sv
// APB master that runs a stored command program (writes, reads, compares, irq waits, delays).
// Latency: first PSEL two cycles after start; one FETCH cycle between consecutive commands.
// Backpressure: ACCESS holds until PREADY; WAIT holds until irq, timeout or delay expiry.
module apb_seq_master
    import apb_seq_pkg::*;
#(
    parameter int APB_AW  = 32,
    parameter int APB_DW  = 32,
    parameter int DEPTH   = 16,
    parameter int NUM_IRQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                                 PCLK,
    input  logic                                 PRESET,
    input  logic                                 cmd_we,
    input  logic [$clog2(DEPTH)-1:0]             cmd_waddr,
    input  logic [cmd_width(APB_AW, APB_DW)-1:0] cmd_wdata,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [$clog2(DEPTH)-1:0]             err_idx,
    output logic [APB_DW-1:0]                    rd_data,
    output logic                                 rd_valid,
    output logic                                 PSEL,
    output logic                                 PENABLE,
    output logic                                 PWRITE,
    output logic [APB_AW-1:0]                    PADDR,
    output logic [APB_DW-1:0]                    PWDATA,
    input  logic [APB_DW-1:0]                    PRDATA,
    input  logic                                 PREADY,
    input  logic                                 PSLVERR,
    input  logic [NUM_IRQ-1:0]                   irq
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CMD_W    = cmd_width(APB_AW, APB_DW);
    localparam int MASK_LSB = mask_lsb();
    localparam int DATA_LSB = data_lsb(APB_DW);
    localparam int ADDR_LSB = addr_lsb(APB_DW);
    localparam int OP_LSB   = op_lsb(APB_AW, APB_DW);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [APB_DW-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               pwrite_q, pwrite_d;
    logic [APB_AW-1:0]  paddr_q, paddr_d;
    logic [APB_DW-1:0]  pwdata_q, pwdata_d;

    logic [CMD_W-1:0]   cmd_rdata;
    op_e                cur_op;
    logic [APB_AW-1:0]  cur_addr;
    logic [APB_DW-1:0]  cur_data;
    logic [APB_DW-1:0]  cur_mask;
    logic [CNT_W-1:0]   delay_len;
    logic [CNT_W-1:0]   irq_tmo;
    logic [7:0]         irq_ext;
    logic               irq_hit;
    logic               is_read;
    logic               cmp_miss;
    logic               advance;
    logic               fail;
    logic               mem_we;

    // Program writes only land while idle so a running sequence never sees its program change.
    assign mem_we = cmd_we && (state_q == ST_IDLE);

    apb_seq_cmd_mem #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_mem (
        .clk_i   (PCLK),
        .we_i    (mem_we),
        .waddr_i (cmd_waddr),
        .wdata_i (cmd_wdata),
        .raddr_i (pc_d),
        .rdata_o (cmd_rdata)
    );

    // The read port follows pc, so the current command stays on cmd_rdata for its whole lifetime.
    assign cur_op    = op_e'(cmd_rdata[OP_LSB +: OP_W]);
    assign cur_addr  = cmd_rdata[ADDR_LSB +: APB_AW];
    assign cur_data  = cmd_rdata[DATA_LSB +: APB_DW];
    assign cur_mask  = cmd_rdata[MASK_LSB +: APB_DW];
    assign delay_len = cur_data[CNT_W-1:0];
    assign irq_tmo   = cur_mask[CNT_W-1:0];
    assign is_read   = (cur_op == OP_RD) || (cur_op == OP_RDCMP);
    assign cmp_miss  = ((PRDATA ^ cur_data) & cur_mask) != '0;

    // Widen irq to the full 3-bit selector range; selecting a missing line never passes.
    always_comb begin
        irq_ext              = '0;
        irq_ext[NUM_IRQ-1:0] = irq;
    end

    assign irq_hit = irq_ext[cur_data[2:0]];

    // Next-state and datapath decode; advance/fail funnel all command completions.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        error_d    = error_q;
        err_idx_d  = err_idx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        advance    = 1'b0;
        fail       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                end
            end

            ST_FETCH: begin
                case (cur_op)
                    OP_NOP: begin
                        advance = 1'b1;
                    end
                    OP_WR, OP_RD, OP_RDCMP: begin
                        state_d  = ST_SETUP;
                        paddr_d  = cur_addr;
                        pwdata_d = cur_data;
                        pwrite_d = (cur_op == OP_WR);
                    end
                    OP_WAITIRQ: begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                    OP_DELAY: begin
                        if (delay_len == '0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = ST_FIN;
                    end
                endcase
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    if (is_read) begin
                        rd_data_d  = PRDATA;
                        rd_valid_d = 1'b1;
                    end
                    if (PSLVERR || ((cur_op == OP_RDCMP) && cmp_miss)) begin
                        fail = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (cur_op == OP_WAITIRQ) begin
                    // irq wins over timeout when both land in the same cycle.
                    if (irq_hit) begin
                        advance = 1'b1;
                    end else if ((irq_tmo != '0) && (cnt_q == irq_tmo - CNT_W'(1))) begin
                        fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q == delay_len - CNT_W'(1)) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail) begin
            error_d   = 1'b1;
            err_idx_d = pc_q;
            state_d   = ST_FIN;
        end else if (advance) begin
            // The last entry ends the program; pc never wraps back to 0.
            if (pc_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_FIN;
            end else begin
                pc_d    = pc_q + IDX_W'(1);
                state_d = ST_FETCH;
            end
        end
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            cnt_q      <= '0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
        end
    end

    // Controls decode straight from the state register so reset drops them immediately.
    assign PSEL     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE  = (state_q == ST_ACCESS);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign error    = error_q;
    assign err_idx  = err_idx_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_apb_seq_master.sv
// Bench for apb_seq_master: table of programs, APB slave model, scoreboard queues for transfers/reads.
// Latency: all timing checked in cycles relative to the start cycle.
// Backpressure: slave inserts a per-test number of wait states.
module tb_apb_seq_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CMDW = 3 + AW + 2 * DW;
    localparam int NV   = 11;

    localparam logic [2:0] B_NOP = 3'd0, B_WR = 3'd1, B_RD = 3'd2, B_RDCMP = 3'd3;
    localparam logic [2:0] B_WAITIRQ = 3'd4, B_DELAY = 3'd5, B_OP6 = 3'd6, B_END = 3'd7;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b1;
    logic            cmd_we = 1'b0;
    logic [3:0]      cmd_waddr = '0;
    logic [CMDW-1:0] cmd_wdata = '0;
    logic            start = 1'b0;
    logic            busy, done, error, rd_valid;
    logic [3:0]      err_idx;
    logic [DW-1:0]   rd_data;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA = '0;
    logic            PREADY = 1'b0;
    logic            PSLVERR = 1'b0;
    logic [1:0]      irq = '0;

    apb_seq_master #(
        .APB_AW(AW), .APB_DW(DW), .DEPTH(16), .NUM_IRQ(2), .CNT_W(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cmd_we(cmd_we), .cmd_waddr(cmd_waddr),
        .cmd_wdata(cmd_wdata), .start(start), .busy(busy), .done(done), .error(error),
        .err_idx(err_idx), .rd_data(rd_data), .rd_valid(rd_valid), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        string           name;
        logic [CMDW-1:0] c0, c1, c2;
        int              ws;
        logic [31:0]     rdval;
        bit              slverr;
        int              irq_at;
        int              n_xfer;
        xfer_t           x0;
        bit              exp_rd;
        logic [31:0]     exp_rdata;
        bit              exp_err;
        int              exp_idx;
        int              exp_cycles;
        int              exp_psel;
    } vec_t;

    vec_t        vecs[NV];
    xfer_t       xq[$];
    logic [31:0] rq[$];
    xfer_t       mon_x;
    logic [31:0] mon_r;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          first_psel = -1;
    int          done_cnt = 0;
    int          done_rel = -1;
    int          pen_cnt = 0;
    int          acc_k = 0;
    int          ws_cfg = 0;
    logic [31:0] rdval_cfg = '0;
    bit          slverr_cfg = 1'b0;
    bit          mon_en = 1'b0;
    logic        done_err = 1'b0;
    logic [3:0]  done_idx = '0;
    logic [31:0] setup_addr = '0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic logic [CMDW-1:0] mk(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] d, input logic [31:0] m);
        return {op, a, d, m};
    endfunction

    function automatic xfer_t mkx(input logic wr, input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.wr = wr; x.addr = a; x.wdata = d;
        return x;
    endfunction

    function automatic vec_t mkv(input string nm, input logic [CMDW-1:0] c0, c1, c2,
                                 input int ws, input logic [31:0] rdval, input bit slverr,
                                 input int irq_at, input int n_xfer, input xfer_t x0,
                                 input bit exp_rd, input logic [31:0] exp_rdata,
                                 input bit exp_err, input int exp_idx,
                                 input int exp_cycles, input int exp_psel);
        vec_t v;
        v.name = nm; v.c0 = c0; v.c1 = c1; v.c2 = c2;
        v.ws = ws; v.rdval = rdval; v.slverr = slverr; v.irq_at = irq_at;
        v.n_xfer = n_xfer; v.x0 = x0; v.exp_rd = exp_rd; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_idx = exp_idx; v.exp_cycles = exp_cycles;
        v.exp_psel = exp_psel;
        return v;
    endfunction

    always @(posedge PCLK) cyc++;

    // APB slave: PREADY after ws_cfg wait states in ACCESS, PSLVERR on the ready cycle if armed.
    always @(posedge PCLK) begin
        #1;
        if (PSEL && PENABLE) begin
            PREADY = (acc_k == ws_cfg);
            acc_k++;
        end else begin
            PREADY = 1'b0;
            acc_k  = 0;
        end
        PSLVERR = PREADY & slverr_cfg;
        PRDATA  = rdval_cfg;
    end

    // Monitor on the falling edge: scoreboard pops for APB transfers and read returns.
    always @(negedge PCLK) begin
        if (mon_en) begin
            if (PSEL && first_psel < 0) first_psel = cyc - t0;
            if (PSEL && !PENABLE) begin
                pen_cnt    = 0;
                setup_addr = PADDR;
            end
            if (PSEL && PENABLE) pen_cnt++;
            if (PSEL && PENABLE && PREADY) begin
                chk("xfer_expected", (xq.size() > 0), 1);
                if (xq.size() > 0) begin
                    mon_x = xq.pop_front();
                    chk("xfer_addr", PADDR, mon_x.addr);
                    chk("xfer_write", PWRITE, mon_x.wr);
                    if (mon_x.wr) chk("xfer_wdata", PWDATA, mon_x.wdata);
                    chk("addr_stable", setup_addr, PADDR);
                    chk("penable_cycles", pen_cnt, ws_cfg + 1);
                end
            end
            if (rd_valid) begin
                chk("rd_expected", (rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    mon_r = rq.pop_front();
                    chk("rd_data", rd_data, mon_r);
                end
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
                done_err = error;
                done_idx = err_idx;
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic load(input int idx, input logic [CMDW-1:0] val);
        cmd_we    = 1'b1;
        cmd_waddr = 4'(idx);
        cmd_wdata = val;
        step();
        cmd_we    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        bit got;
        load(0, v.c0);
        load(1, v.c1);
        load(2, v.c2);
        ws_cfg     = v.ws;
        rdval_cfg  = v.rdval;
        slverr_cfg = v.slverr;
        if (v.n_xfer > 0) xq.push_back(v.x0);
        if (v.exp_rd) rq.push_back(v.exp_rdata);
        d0         = done_cnt;
        first_psel = -1;
        t0         = cyc;
        start      = 1'b1;
        if (v.irq_at == 0) irq = 2'b10;
        got = 1'b0;
        for (int rel = 1; rel < 300 && !got; rel++) begin
            step();
            start = 1'b0;
            if (rel == 1) chk({v.name, "_busy"}, busy, 1);
            if (rel == v.irq_at) irq = 2'b10;
            if (done_cnt != d0) got = 1'b1;
        end
        chk({v.name, "_done_seen"}, got, 1);
        chk({v.name, "_done_cycle"}, done_rel, v.exp_cycles);
        chk({v.name, "_error"}, done_err, v.exp_err);
        chk({v.name, "_err_idx"}, done_idx, v.exp_idx);
        chk({v.name, "_first_psel"}, first_psel, v.exp_psel);
        chk({v.name, "_done_low"}, done, 0);
        chk({v.name, "_idle"}, busy, 0);
        chk({v.name, "_error_sticky"}, error, v.exp_err);
        chk({v.name, "_xfers_left"}, xq.size(), 0);
        chk({v.name, "_reads_left"}, rq.size(), 0);
        xq.delete();
        rq.delete();
        irq        = 2'b00;
        slverr_cfg = 1'b0;
    endtask

    initial begin
        logic [CMDW-1:0] E;
        int d0;
        E = mk(B_END, 0, 0, 0);

        vecs[0]  = mkv("wr_basic", mk(B_WR, 'h10, 'hA5A5_0000, 0), E, E, 0, 0, 0, -1,
                       1, mkx(1, 'h10, 'hA5A5_0000), 0, 0, 0, 0, 5, 2);
        vecs[1]  = mkv("rdcmp_ws3", mk(B_RDCMP, 'h14, 'hF0, 'hFF), E, E, 3, 'h1234_56F0, 0, -1,
                       1, mkx(0, 'h14, 0), 1, 'h1234_56F0, 0, 0, 8, 2);
        vecs[2]  = mkv("rdcmp_miss", mk(B_RDCMP, 'h14, 'hF0, 'hFF), mk(B_WR, 'h20, 'h77, 0), E,
                       3, 'hF1, 0, -1, 1, mkx(0, 'h14, 0), 1, 'hF1, 1, 0, 7, 2);
        vecs[3]  = mkv("waitirq_hit", mk(B_WAITIRQ, 0, 1, 20), mk(B_WR, 0, 1, 0), E, 0, 0, 0, 10,
                       1, mkx(1, 0, 1), 0, 0, 0, 0, 15, 12);
        vecs[4]  = mkv("waitirq_tmo", mk(B_WAITIRQ, 0, 1, 20), mk(B_WR, 0, 1, 0), E, 0, 0, 0, -1,
                       0, mkx(0, 0, 0), 0, 0, 1, 0, 22, -1);
        vecs[5]  = mkv("slverr", mk(B_NOP, 0, 0, 0), mk(B_WR, 'h30, 'hDEAD_BEEF, 0), E, 1, 0, 1, -1,
                       1, mkx(1, 'h30, 'hDEAD_BEEF), 0, 0, 1, 1, 6, 3);
        vecs[6]  = mkv("delay5_rd", mk(B_DELAY, 0, 5, 0), mk(B_RD, 'h40, 0, 0), E, 0, 'hCAFE_F00D, 0,
                       -1, 1, mkx(0, 'h40, 0), 1, 'hCAFE_F00D, 0, 0, 11, 8);
        vecs[7]  = mkv("delay0", mk(B_DELAY, 0, 0, 0), E, E, 0, 0, 0, -1,
                       0, mkx(0, 0, 0), 0, 0, 0, 0, 3, -1);
        vecs[8]  = mkv("op6_end", mk(B_OP6, 0, 0, 0), mk(B_WR, 'h60, 1, 0), E, 0, 0, 0, -1,
                       0, mkx(0, 0, 0), 0, 0, 0, 0, 2, -1);
        vecs[9]  = mkv("irq_early", mk(B_WAITIRQ, 0, 1, 20), E, E, 0, 0, 0, 0,
                       0, mkx(0, 0, 0), 0, 0, 0, 0, 4, -1);
        vecs[10] = mkv("rdcmp_mask", mk(B_RDCMP, 'h18, 'h05, 'h0F), E, E, 0, 'hFFFF_FF05, 0, -1,
                       1, mkx(0, 'h18, 0), 1, 'hFFFF_FF05, 0, 0, 5, 2);

        // Outputs while reset is held.
        repeat (3) step();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        PRESET = 1'b0;
        step();
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Sixteen NOPs: ends after entry 15 with no wrap; start and cmd_we mid-run are dropped.
        for (int i = 0; i < 16; i++) load(i, mk(B_NOP, 0, 0, 0));
        d0         = done_cnt;
        first_psel = -1;
        t0         = cyc;
        start      = 1'b1;
        for (int rel = 1; rel < 60 && done_cnt == d0; rel++) begin
            step();
            start  = 1'b0;
            cmd_we = 1'b0;
            if (rel == 3) begin
                start     = 1'b1;
                cmd_we    = 1'b1;
                cmd_waddr = 4'd5;
                cmd_wdata = E;
            end
        end
        chk("nop_done_cycle", done_rel, 17);
        chk("nop_error", done_err, 0);
        chk("nop_no_apb", first_psel, -1);
        repeat (6) step();
        chk("nop_single_done", done_cnt - d0, 1);
        chk("nop_no_restart", busy, 0);

        // Reset in the middle of a long ACCESS phase.
        load(0, mk(B_WR, 'h50, 'h1122_3344, 0));
        load(1, E);
        mon_en = 1'b0;
        ws_cfg = 20;
        start  = 1'b1;
        for (int rel = 1; rel <= 4; rel++) begin
            step();
            start = 1'b0;
        end
        chk("mid_in_access", PENABLE, 1);
        PRESET = 1'b1;
        #1;
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_paddr", PADDR, 0);
        chk("mid_rst_pwdata", PWDATA, 0);
        step();
        PRESET = 1'b0;
        step();
        ws_cfg = 0;
        mon_en = 1'b1;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
